prog_loader: RTL and testbench

Upstream framing and load stage for the 8-bit memory processor. It accepts a byte stream over a valid/ready handshake and hunts for a sync byte. It buffers one program frame, checks its checksum, and replays the frame into the processor's `data_in` in the processor's write order: start address, then instruction/data pairs. When the replay finishes it raises `start`. Frames with a bad checksum or bad length are dropped and never reach the processor.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/byte_fifo.sv | 47 ++++
 rtl/prog_loader.sv | 165 ++++++++++++++++
 tb/tb_prog_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the loader state encoding and processor opcodes.
package loader_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOVA  = 4'h1;
  localparam logic [3:0] OP_MOVB  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h8;
  localparam logic [3:0] OP_MOVAM = 4'h9;
  localparam logic [3:0] OP_MOVBM = 4'hA;
  localparam logic [3:0] OP_MOVM  = 4'hC;

  typedef enum logic [3:0] {
    S_HUNT,
    S_ADDR,
    S_COUNT,
    S_PAYLOAD,
    S_CSUM,
    S_PRST,
    S_SADDR,
    S_SEND,
    S_DONE
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO holding one frame payload.
// Single-cycle flush discards a rejected frame.
module byte_fifo import loader_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/prog_loader.sv
// Frame hunter, checksum checker and replay engine
// feeding the 8-bit processor's data_in/start.
module prog_loader import loader_pkg::*; #(
  parameter int                DEPTH = 16,
  parameter logic [BYTE_W-1:0] SYNC  = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_start,
  output logic              proc_rst_n,
  output logic              busy,
  output logic              err
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_d;
  logic [BYTE_W-1:0] acc, acc_d;
  logic [BYTE_W-1:0] addr, addr_d;
  logic [BYTE_W-1:0] data_d;
  logic [LW-1:0]     len, len_d;
  logic [LW-1:0]     bcnt, bcnt_d;
  logic              start_d;
  logic              err_d;
  logic              xfer;
  logic              push, pop, flush;
  logic              f_full, f_empty;
  logic [BYTE_W-1:0] f_rdata;
  logic [8:0]        twice;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .flush (flush),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign in_ready = !(state inside {S_PRST, S_SADDR, S_SEND});
  assign xfer     = in_valid && in_ready;
  assign twice    = {in_data, 1'b0};

  // Next-state, checksum and replay-output decode.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    addr_d  = addr;
    len_d   = len;
    bcnt_d  = bcnt;
    data_d  = out_data;
    start_d = out_start;
    err_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    unique case (state)
      S_HUNT, S_DONE: begin
        if (xfer && in_data == SYNC) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (xfer) begin
          addr_d  = in_data;
          acc_d   = in_data;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          acc_d  = acc + in_data;
          len_d  = twice[LW-1:0];
          bcnt_d = '0;
          if (twice > 9'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else if (in_data == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          push   = !f_full;
          acc_d  = acc + in_data;
          bcnt_d = bcnt + 1'b1;
          if (bcnt_d == len) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (in_data == acc) begin
            state_d = S_PRST;
          end else begin
            err_d   = 1'b1;
            flush   = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
      S_PRST: begin
        data_d  = addr;
        state_d = S_SADDR;
      end
      S_SADDR: begin
        if (len == '0) begin
          start_d = 1'b1;
          state_d = S_DONE;
        end else begin
          pop     = 1'b1;
          data_d  = f_rdata;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!f_empty) begin
          pop    = 1'b1;
          data_d = f_rdata;
        end else begin
          start_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_HUNT;
    endcase
    if (state_d == S_PRST) start_d = 1'b0;
  end

  // State, datapath and registered processor-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_HUNT;
      acc        <= '0;
      addr       <= '0;
      len        <= '0;
      bcnt       <= '0;
      out_data   <= '0;
      out_start  <= 1'b0;
      proc_rst_n <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      addr       <= addr_d;
      len        <= len_d;
      bcnt       <= bcnt_d;
      out_data   <= data_d;
      out_start  <= start_d;
      proc_rst_n <= (state_d != S_PRST);
      err        <= err_d;
      busy       <= !(state_d inside {S_HUNT, S_DONE});
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a frame-level
// reference model and per-cycle output comparison.
module tb_prog_loader;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_start;
  logic       proc_rst_n;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(DEPTH), .SYNC(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_start  (out_start),
    .proc_rst_n (proc_rst_n),
    .busy       (busy),
    .err        (err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit         in_frame = 1'b0;
  logic [7:0] fb[$];
  int         blocked_until = -1;
  logic [7:0] sched_data[int];
  bit         sched_start[int];
  bit         sched_low[int];
  bit         sched_err[int];
  logic [7:0] exp_data = 8'h00;
  bit         exp_start = 1'b0;
  bit         post_rst = 1'b1;

  int         low_cnt = 0;
  int         low_cyc = -1;
  int         err_cnt = 0;
  logic [7:0] data_at[int];
  logic       start_at[int];

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_clear();
    in_frame = 1'b0;
    fb.delete();
    blocked_until = -1;
    sched_data.delete();
    sched_start.delete();
    sched_low.delete();
    sched_err.delete();
    exp_data = 8'h00;
    exp_start = 1'b0;
  endfunction

  // Frame-level parse: position in frame decides meaning.
  function automatic void model_accept(logic [7:0] b, int e);
    int n;
    int c;
    logic [7:0] s;
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1'b1;
        fb.delete();
      end
      return;
    end
    fb.push_back(b);
    n = fb.size();
    if (n < 2) return;
    c = int'(fb[1]);
    if (n == 2 && 2 * c > DEPTH) begin
      sched_err[e+1] = 1'b1;
      in_frame = 1'b0;
      return;
    end
    if (n == 3 + 2 * c) begin
      s = 8'h00;
      for (int i = 0; i < n - 1; i++) s = s + fb[i];
      if (s == fb[n-1]) begin
        sched_low[e+1] = 1'b1;
        sched_start[e+1] = 1'b0;
        sched_data[e+2] = fb[0];
        for (int k = 0; k < 2 * c; k++) sched_data[e+3+k] = fb[2+k];
        sched_start[e+3+2*c] = 1'b1;
        blocked_until = e + 2 + 2 * c;
      end else begin
        sched_err[e+1] = 1'b1;
      end
      in_frame = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (in_valid && cyc > blocked_until) model_accept(in_data, cyc);
    end
  end

  always @(negedge clk) begin
    int c;
    c = cyc + 1;
    if (rst) begin
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_start", out_start, 1'b0);
      chk("rst_proc_rst_n", proc_rst_n, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end else begin
      if (sched_data.exists(c)) exp_data = sched_data[c];
      if (sched_start.exists(c)) exp_start = sched_start[c];
      chk("out_data", out_data, exp_data);
      chk("out_start", out_start, exp_start);
      chk("proc_rst_n", proc_rst_n,
          !post_rst && !sched_low.exists(c));
      chk("err", err, sched_err.exists(c));
      chk("busy", busy, in_frame || c <= blocked_until);
      chk("in_ready", in_ready, c > blocked_until);
      data_at[c] = out_data;
      start_at[c] = out_start;
      if (!proc_rst_n && !post_rst) begin
        low_cnt++;
        low_cyc = c;
      end
      if (err) err_cnt++;
    end
  end

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(logic [7:0] b);
    int guard;
    bit taken;
    guard = 0;
    taken = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    while (!taken && guard < 200) begin
      taken = (cyc + 1 > blocked_until);
      @(posedge clk);
      #2;
      guard++;
    end
    if (!taken) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout byte %h not accepted", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gap);
    foreach (f[i]) begin
      send(f[i]);
      if (gap) idle(1);
    end
  endtask

  function automatic logic [7:0] get_d(int c);
    if (data_at.exists(c)) return data_at[c];
    return 8'hxx;
  endfunction

  function automatic logic get_s(int c);
    if (start_at.exists(c)) return start_at[c];
    return 1'bx;
  endfunction

  // Literal checks of one replay against hand-written bytes.
  task automatic pin_load(string tag, input logic [7:0] seq[$],
                          input int l0);
    chk({tag, "_prst_once"}, 8'(low_cnt - l0), 8'd1);
    foreach (seq[i])
      chk({tag, "_seq"}, get_d(low_cyc + 1 + i), seq[i]);
    chk({tag, "_start_lo"}, get_s(low_cyc + seq.size()), 1'b0);
    chk({tag, "_start_hi"}, get_s(low_cyc + 1 + seq.size()), 1'b1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    post_rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] f1[$];
    logic [7:0] fbad[$];
    logic [7:0] s1[$];
    logic [7:0] tmp[$];
    int l0;
    int e0;
    f1   = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h05, 8'h22, 8'h07, 8'h51};
    fbad = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h05, 8'h22, 8'h07, 8'h50};
    s1   = '{8'h10, 8'h11, 8'h05, 8'h22, 8'h07};

    #1 rst = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);

    l0 = low_cnt; e0 = err_cnt;
    send_frame(f1, 1'b0);
    idle(12);
    pin_load("good", s1, l0);
    chk("good_no_err", 8'(err_cnt - e0), 8'd0);

    l0 = low_cnt; e0 = err_cnt;
    send_frame(fbad, 1'b0);
    idle(6);
    chk("badcs_err", 8'(err_cnt - e0), 8'd1);
    chk("badcs_no_prst", 8'(low_cnt - l0), 8'd0);
    chk("badcs_start_held", out_start, 1'b1);

    l0 = low_cnt;
    send_frame(f1, 1'b0);
    idle(12);
    pin_load("after_bad", s1, l0);

    l0 = low_cnt; e0 = err_cnt;
    tmp = '{8'hA5, 8'h00, 8'h09};
    send_frame(tmp, 1'b0);
    for (int i = 1; i <= 18; i++) send(8'(i));
    idle(4);
    chk("ovf_err", 8'(err_cnt - e0), 8'd1);
    chk("ovf_no_prst", 8'(low_cnt - l0), 8'd0);

    l0 = low_cnt;
    tmp = '{8'h00, 8'hFF, 8'h3C};
    send_frame(tmp, 1'b0);
    send_frame(f1, 1'b0);
    idle(12);
    pin_load("garbage", s1, l0);

    l0 = low_cnt;
    tmp = '{8'hA5, 8'h20, 8'h00, 8'h20};
    send_frame(tmp, 1'b0);
    idle(8);
    s1 = '{8'h20};
    pin_load("cnt0", s1, l0);

    tmp = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h05, 8'h22};
    send_frame(tmp, 1'b0);
    do_reset();
    chk("rst_fifo_empty", dut.u_fifo.empty, 1'b1);
    idle(2);
    l0 = low_cnt;
    send_frame(f1, 1'b0);
    idle(12);
    s1 = '{8'h10, 8'h11, 8'h05, 8'h22, 8'h07};
    pin_load("post_rst", s1, l0);

    l0 = low_cnt;
    send_frame(f1, 1'b1);
    idle(12);
    pin_load("gappy", s1, l0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
